// File: rtl/pulse_sched_pkg.sv
// Shared types and default timing for the pulse display scheduler.
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    // Defaults for the 100 MHz clock-wizard domain: 1 s on, 0.5 s gap.
    localparam int unsigned DEFAULT_ON_CYCLES  = 100_000_000;
    localparam int unsigned DEFAULT_GAP_CYCLES = 50_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]         req_i,
    input  logic [$clog2(N_CH)-1:0] ptr_i,
    output logic                    gnt_valid_o,
    output logic [$clog2(N_CH)-1:0] gnt_idx_o
);

    localparam int unsigned SEL_W = $clog2(N_CH);

    int unsigned idx;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(ptr_i) + k) % N_CH;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pulse_display_scheduler.sv
// Shares one indicator LED among N_CH pulse channels: saturating pending counts,
// round-robin grants, one fixed on/gap blink per grant.
module pulse_display_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int unsigned TIMER_W    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_CH-1:0]         pulse_i,
    input  logic                    enable_i,
    input  logic                    clr_overflow_i,
    input  logic [$clog2(N_CH)-1:0] cnt_sel_i,
    output logic [CNT_W-1:0]        cnt_out_o,
    output logic                    led_o,
    output logic                    busy_o,
    output logic [$clog2(N_CH)-1:0] active_ch_o,
    output logic                    pending_any_o,
    output logic [N_CH-1:0]         overflow_o
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

    sched_state_t       state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               led_q, led_d;
    logic [SEL_W-1:0]   active_ch_q, active_ch_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q [N_CH];
    logic [CNT_W-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0]    ovf_q, ovf_d;
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    dec;
    logic               gnt_valid;
    logic [SEL_W-1:0]   gnt_idx;
    logic               grant;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_arb (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    assign grant = (state_q == IDLE) && enable_i && gnt_valid;

    // A pulse coinciding with the grant decrement cancels it; a saturation set beats a clear.
    always_comb begin
        ovf_d = clr_overflow_i ? '0 : ovf_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            dec[i]   = grant && (gnt_idx == SEL_W'(i));
            cnt_d[i] = cnt_q[i];
            if (pulse_i[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (dec[i] && !pulse_i[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        led_d       = led_q;
        active_ch_d = active_ch_q;
        ptr_d       = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d     = ON;
                    led_d       = 1'b1;
                    timer_d     = ON_LOAD;
                    active_ch_d = gnt_idx;
                    ptr_d       = gnt_idx;
                end
            end
            ON: begin
                if (timer_q == '0) begin
                    state_d = GAP;
                    led_d   = 1'b0;
                    timer_d = GAP_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            led_q       <= 1'b0;
            active_ch_q <= '0;
            ptr_q       <= SEL_W'(N_CH - 1);
            ovf_q       <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            led_q       <= led_d;
            active_ch_q <= active_ch_d;
            ptr_q       <= ptr_d;
            ovf_q       <= ovf_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt_out_o = '0;
        if (32'(cnt_sel_i) < N_CH) begin
            cnt_out_o = cnt_q[cnt_sel_i];
        end
    end

    assign led_o         = led_q;
    assign busy_o        = (state_q != IDLE);
    assign active_ch_o   = active_ch_q;
    assign pending_any_o = |req;
    assign overflow_o    = ovf_q;

endmodule

// File: doc/pulse_display_scheduler.md
Name: pulse_display_scheduler

Overview:
- Shares one indicator LED among N_CH synchronized pulse channels, one output per posedge detector instance.
- Keeps a saturating per-channel count of pending pulses.
- A round-robin arbiter grants one channel at a time; each grant plays one fixed-length LED blink (on period, then gap) and retires one pending pulse.
- Sits between the per-channel posedge detectors and the LED output pin, in the 100 MHz clock-wizard domain.

Parameters:
- N_CH, 4, number of pulse channels (>=2)
- CNT_W, 16, width of each pending-pulse counter
- ON_CYCLES, 100_000_000, LED-high duration per blink in clk cycles (>=1)
- GAP_CYCLES, 50_000_000, LED-low gap after each blink in clk cycles (>=1)
- TIMER_W, 32, phase timer width; must hold max(ON_CYCLES, GAP_CYCLES)-1

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- pulse  in  N_CH  single-cycle synchronized detections, one bit per channel
- enable  in  1  permits new grants; an in-progress blink always completes
- clr_overflow  in  1  single-cycle clear of all overflow flags
- cnt_sel  in  $clog2(N_CH)  channel selected for count readout
- cnt_out  out  CNT_W  pending count of channel cnt_sel, combinational from the registered counter
- led  out  1  registered LED drive
- busy  out  1  high in ON and GAP
- active_ch  out  $clog2(N_CH)  channel of the current or last grant
- pending_any  out  1  OR of all pending counts being nonzero
- overflow  out  N_CH  sticky per-channel saturation flags

Behaviour:
- Reset: one clock; asynchronous, active-low (rst_n). While rst_n=0: all counters 0, led=0, busy=0, active_ch=0, overflow=0, state=IDLE, RR pointer=N_CH-1 (ch0 has highest priority first).
- Reset asserted mid-blink: led drops immediately (async); all pending counts are lost.
- Counters, per channel per cycle:
  - pulse only: +1, saturating at 2^CNT_W-1.
  - pulse while saturated: count holds, overflow[ch] set.
  - grant decrement only: -1.
  - pulse and grant decrement in the same cycle: count unchanged.
- Overflow: clr_overflow clears all flags. If clr_overflow and a new saturation event occur in the same cycle, the set wins.
- FSM states: IDLE, ON, GAP.
  - IDLE: if enable and any registered count is nonzero, the arbiter picks the first nonzero channel after the pointer (wrapping). Same edge: state<=ON, led<=1, timer<=ON_CYCLES-1, active_ch<=ch, pointer<=ch, count[ch] decremented.
  - ON: timer decrements each cycle. At timer==0: state<=GAP, led<=0, timer<=GAP_CYCLES-1.
  - GAP: timer decrements each cycle. At timer==0: state<=IDLE.
- Timing:
  - led is high for exactly ON_CYCLES cycles per grant.
  - Minimum grant-to-grant spacing is ON_CYCLES+GAP_CYCLES+1 cycles (one IDLE evaluation cycle).
  - A pulse in cycle t is first eligible for grant in cycle t+1; led rises at t+2.
- enable=0 during ON/GAP: the blink finishes normally, then the FSM stays in IDLE. Counts keep accumulating.
- pending_any is combinational from the registered counts.

Decomposition:
- Package pulse_sched_pkg holds:
  - typedef enum sched_state_t {IDLE, ON, GAP}
  - default ON_CYCLES/GAP_CYCLES localparams at 100 MHz
- Sub-module rr_arbiter (parameter N_CH):
  - inputs: req[N_CH], ptr
  - outputs: gnt_valid, gnt_idx
  - purely combinational; the pointer register lives in the parent.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, CNT_W=3, N_CH=4 unless stated):
- pulse[0] high in cycle 10 only, enable=1 -> led high cycles 12-15 and low from 16; busy high 12-17; active_ch=0; cnt_out(sel 0)=0 from cycle 12.
- pulse[1], pulse[2], pulse[3] simultaneous after reset -> grants in order 1, 2, 3; each led high window is 4 cycles; successive rising edges are 7 cycles apart.
- enable=0, 9 pulses on ch1 -> cnt_out=7 and overflow[1]=1 after the 8th pulse. clr_overflow -> overflow=0 and count stays 7.
- ch2 count=1 and pulse[2] asserted in the grant cycle -> count stays 1 after the grant; a second blink for ch2 follows.
- rst_n low in the 2nd ON cycle -> led=0 in the same cycle; all counts 0, busy=0. After release and no pulses, led stays 0.
- enable dropped in the 1st ON cycle with ch0 count=2 -> that blink completes; no further grant; count stays 1 until enable returns.
